prog_clock_divider: RTL and testbench
=====================================

// Module: prog_clock_divider
// PURPOSE
//  Multi-channel, runtime-programmable clock divider for the rover FPGA fabric.
//  Generates NUM_CH independent divided clocks/enables from the single clk_in.
//  Each channel has a programmable period and high time (duty cycle).
//  Divisor changes take effect only at a period boundary, so no channel emits a runt pulse.
//  Sits beside the motor/sensor blocks. Outputs are registered fabric signals.
//  Use tick as a clock enable. Global buffering of clk_div_out is the integrator's responsibility.
// PARAMETERS
//  NUM_CH       4      number of independent divider channels (1..16)
//  CNT_W        28     counter / divisor width in bits
//  DEFAULT_DIV  2      active divisor for every channel after reset (>=2)
// PORTS
//  clk_in       in   1                  system clock (100 MHz)
//  rst_n        in   1                  synchronous reset, active low
//  ch_en        in   NUM_CH             per-channel run enable (level)
//  cfg_we       in   1                  config write strobe, one cycle
//  cfg_ch       in   max(1,$clog2(NUM_CH))  target channel of write
//  cfg_div      in   CNT_W              new period in clk_in cycles
//  cfg_hi       in   CNT_W              new high time in cycles; 0 = div/2 (floor)
//  cfg_ack      out  1                  write accepted, 1-cycle pulse
//  cfg_err      out  1                  write rejected, 1-cycle pulse
//  clk_div_out  out  NUM_CH             divided clock per channel
//  tick         out  NUM_CH             1-cycle pulse at start of each period
// BEHAVIOUR
//  Reset (rst_n low at posedge):
//  - All outputs are 0. Every cnt is 0. All channels are in IDLE.
//  - Active div = DEFAULT_DIV, active hi = DEFAULT_DIV/2. pending flags are clear.
//  Per-channel state: IDLE, RUN, RUN_PEND.
//  - IDLE -> RUN when ch_en=1 is sampled.
//    The next cycle shows cnt=0, tick=1 and clk_div_out=1.
//  - RUN/RUN_PEND -> IDLE when ch_en=0 is sampled.
//    The next cycle shows cnt=0, tick=0 and clk_div_out=0.
//    Any pending config is promoted to active on this transition.
//  Counting in RUN:
//  - cnt goes 0..div-1 and then wraps to 0.
//  - Registered outputs: clk_div_out = (cnt < hi), tick = (cnt == 0) && running.
//  - Period = div cycles exactly. DIV=2/hi=1 gives a 50 MHz square wave.
//  Config write (cfg_we sampled high):
//  - Error cases: reject with cfg_err on the next cycle and change no state when
//    cfg_ch >= NUM_CH, cfg_div < 2, or cfg_hi >= cfg_div.
//  - Otherwise cfg_ack is pulsed on the next cycle.
//    The effective hi is (cfg_hi==0 ? cfg_div>>1 : cfg_hi).
//  - Target in IDLE: values become active immediately.
//  - Target running: values are stored as pending and the state goes to RUN_PEND.
//  - Write while already pending: the new values overwrite the pending set (last write wins).
//  - Ack is never withheld.
//  Pending promotion:
//  - Happens at the edge where cnt == active div-1. cnt goes to 0 with the new div/hi.
//    That first cycle uses the new hi; state returns to RUN.
//  - A write landing on that same wrap edge is not promoted at that wrap.
//    It stays pending and is applied at the following wrap.
//  Simultaneous events:
//  - ch_en fall + cfg write to the same channel in one cycle: disable wins.
//    The write is treated as an IDLE-target write, so it is applied immediately and acked.
//  Arithmetic:
//  - Unsigned CNT_W comparisons. No overflow, since cnt <= div-1 < 2^CNT_W.
//  Mid-operation reset:
//  - Returns all channels to IDLE with defaults. Pending writes are discarded.
//  - cfg_ack/cfg_err are forced to 0 that cycle.
// TESTING
//  - Reset, ch_en[0]=1, defaults:
//    - clk_div_out[0] toggles 1,0,1,0 from the cycle after enable.
//    - tick[0] is high every 2nd cycle. All other channels stay 0.
//  - Write ch1 div=5 hi=2 while IDLE, ack, then enable:
//    - clk_div_out[1] pattern is 1,1,0,0,0 repeating.
//    - tick[1] pulses every 5 cycles.
//  - ch2 running div=4, write div=10 hi=0 at cnt=1:
//    - The current period completes as 4 cycles (1,1,0,0).
//    - Then 10-cycle periods with 5 high. No runt pulse.
//  - Two writes to ch3 while running (div=6, then div=8) before wrap: only div=8 is applied.
//  - Rejects, each giving cfg_err=1 with unchanged outputs:
//    - cfg_div=1.
//    - cfg_hi=7 with cfg_div=7.
//    - cfg_ch=NUM_CH when NUM_CH is not a power of two.
//  - rst_n low for 1 cycle mid-period with a pending write:
//    - All outputs are 0 the next cycle.
//    - After re-enable the channel runs DEFAULT_DIV.

Source files
------------

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider. Each channel counts 0..div-1 and drives
// a registered divided clock (cnt < hi) and a period-start tick; reconfiguration is deferred to period wraps.
module prog_clock_divider #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 28,
  parameter int DEFAULT_DIV = 2,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_hi,
  output logic              cfg_ack,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_div_out,
  output logic [NUM_CH-1:0] tick
);

  typedef enum logic [1:0] {IDLE, RUN, RUN_PEND} state_t;

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DEF_HI  = CNT_W'(DEFAULT_DIV / 2);

  logic             cfg_valid;
  logic             cfg_ok;
  logic [CNT_W-1:0] hi_eff;

  assign cfg_valid = ({1'b0, cfg_ch} < (CH_W+1)'(NUM_CH))
                     && (cfg_div >= CNT_W'(2)) && (cfg_hi < cfg_div);
  assign cfg_ok    = cfg_we && cfg_valid;
  assign hi_eff    = (cfg_hi == '0) ? (cfg_div >> 1) : cfg_hi;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_ack <= cfg_ok;
      cfg_err <= cfg_we && !cfg_valid;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      state_t           state_reg, state_next;
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic [CNT_W-1:0] div_reg, div_next;
      logic [CNT_W-1:0] hi_reg, hi_next;
      logic [CNT_W-1:0] pdiv_reg, pdiv_next;
      logic [CNT_W-1:0] phi_reg, phi_next;
      logic             clk_reg, clk_next;
      logic             tick_reg, tick_next;
      logic             wr_hit;
      logic             wrap;

      assign wr_hit = cfg_ok && (cfg_ch == CH_W'(gi));
      assign wrap   = (cnt_reg == div_reg - 1'b1);

      always_comb begin
        state_next = state_reg;
        cnt_next   = '0;
        div_next   = div_reg;
        hi_next    = hi_reg;
        pdiv_next  = pdiv_reg;
        phi_next   = phi_reg;
        clk_next   = 1'b0;
        tick_next  = 1'b0;
        case (state_reg)
          IDLE: begin
            if (wr_hit) begin
              div_next = cfg_div;
              hi_next  = hi_eff;
            end
            // Active hi is always >= 1, so the first cycle of a period is high.
            if (ch_en[gi]) begin
              state_next = RUN;
              clk_next   = 1'b1;
              tick_next  = 1'b1;
            end
          end
          default: begin
            if (!ch_en[gi]) begin
              state_next = IDLE;
              if (state_reg == RUN_PEND) begin
                div_next = pdiv_reg;
                hi_next  = phi_reg;
              end
              if (wr_hit) begin
                div_next = cfg_div;
                hi_next  = hi_eff;
              end
            end else begin
              if (wrap && state_reg == RUN_PEND) begin
                div_next   = pdiv_reg;
                hi_next    = phi_reg;
                state_next = RUN;
              end
              // A write landing on the wrap edge stays pending until the next wrap.
              if (wr_hit) begin
                pdiv_next  = cfg_div;
                phi_next   = hi_eff;
                state_next = RUN_PEND;
              end
              cnt_next  = wrap ? '0 : cnt_reg + 1'b1;
              clk_next  = (cnt_next < hi_next);
              tick_next = (cnt_next == '0);
            end
          end
        endcase
      end

      always_ff @(posedge clk_in) begin
        if (!rst_n) begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          div_reg   <= DEF_DIV;
          hi_reg    <= DEF_HI;
          pdiv_reg  <= '0;
          phi_reg   <= '0;
          clk_reg   <= 1'b0;
          tick_reg  <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          div_reg   <= div_next;
          hi_reg    <= hi_next;
          pdiv_reg  <= pdiv_next;
          phi_reg   <= phi_next;
          clk_reg   <= clk_next;
          tick_reg  <= tick_next;
        end
      end

      assign clk_div_out[gi] = clk_reg;
      assign tick[gi]        = tick_reg;
    end
  endgenerate

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider; five channels so an out-of-range channel index is reachable.
module tb_prog_clock_divider;
  localparam int NUM_CH = 5;
  localparam int CNT_W  = 28;
  localparam int CH_W   = 3;

  logic              clk_in;
  logic              rst_n;
  logic [NUM_CH-1:0] ch_en;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic [CNT_W-1:0]  cfg_hi;
  logic              cfg_ack;
  logic              cfg_err;
  logic [NUM_CH-1:0] clk_div_out;
  logic [NUM_CH-1:0] tick;

  int n_cmp = 0;
  int n_err = 0;

  prog_clock_divider #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(2)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .ch_en(ch_en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_hi(cfg_hi), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
    .clk_div_out(clk_div_out), .tick(tick)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int ch, input int dv, input int hi);
    cfg_we  = 1'b1;
    cfg_ch  = CH_W'(ch);
    cfg_div = CNT_W'(dv);
    cfg_hi  = CNT_W'(hi);
  endtask

  // Observe n cycles of channel ch; bit i of each pattern is the value expected on cycle i.
  task automatic obs_seq(input int ch, input int n, input logic [31:0] cpat,
                         input logic [31:0] tpat, input string tag);
    for (int i = 0; i < n; i++) begin
      step();
      chk($sformatf("%s_clk%0d", tag, i), 32'(clk_div_out[ch]), 32'(cpat[i]));
      chk($sformatf("%s_tick%0d", tag, i), 32'(tick[ch]), 32'(tpat[i]));
    end
  endtask

  initial begin
    rst_n = 1'b0; ch_en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_hi = '0;
    step();
    step();
    chk("rst_clk", 32'(clk_div_out), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_ack", 32'(cfg_ack), 32'h0);
    chk("rst_err", 32'(cfg_err), 32'h0);

    // Defaults on ch0: 50% square wave of period 2
    rst_n = 1'b1;
    ch_en = 5'b00001;
    obs_seq(0, 4, 32'b0101, 32'b0101, "def0");
    chk("def0_others_clk", 32'(clk_div_out[4:1]), 32'h0);
    chk("def0_others_tick", 32'(tick[4:1]), 32'h0);
    ch_en = '0;
    step();
    chk("dis0_clk", 32'(clk_div_out[0]), 32'h0);
    chk("dis0_tick", 32'(tick[0]), 32'h0);

    // ch1 div=5 hi=2 configured while idle
    wr(1, 5, 2);
    step();
    chk("wr1_ack", 32'(cfg_ack), 32'h1);
    chk("wr1_err", 32'(cfg_err), 32'h0);
    cfg_we = 1'b0;
    ch_en  = 5'b00010;
    obs_seq(1, 10, 32'b0001100011, 32'b0000100001, "div5");
    chk("div5_ack_clear", 32'(cfg_ack), 32'h0);
    ch_en = '0;
    step();

    // ch2 div=4, retargeted to div=10 hi=0 at cnt=1
    wr(2, 4, 0);
    step();
    chk("wr2a_ack", 32'(cfg_ack), 32'h1);
    cfg_we = 1'b0;
    ch_en  = 5'b00100;
    obs_seq(2, 2, 32'b11, 32'b01, "ch2a");
    wr(2, 10, 0);
    obs_seq(2, 1, 32'b0, 32'b0, "ch2b");
    chk("wr2b_ack", 32'(cfg_ack), 32'h1);
    cfg_we = 1'b0;
    obs_seq(2, 12, 32'b100000111110, 32'b100000000010, "ch2c");
    ch_en = '0;
    step();

    // ch3: two pending writes in one period, last one wins
    wr(3, 4, 2);
    step();
    cfg_we = 1'b0;
    ch_en  = 5'b01000;
    obs_seq(3, 1, 32'b1, 32'b1, "ch3a");
    wr(3, 6, 0);
    obs_seq(3, 1, 32'b1, 32'b0, "ch3b");
    chk("wr3a_ack", 32'(cfg_ack), 32'h1);
    wr(3, 8, 0);
    obs_seq(3, 1, 32'b0, 32'b0, "ch3c");
    chk("wr3b_ack", 32'(cfg_ack), 32'h1);
    cfg_we = 1'b0;
    obs_seq(3, 10, 32'b1000011110, 32'b1000000010, "ch3d");
    ch_en = '0;
    step();

    // Rejected writes aimed at idle ch0 must leave it on defaults
    wr(0, 1, 0);
    step();
    chk("rej_div1_err", 32'(cfg_err), 32'h1);
    chk("rej_div1_ack", 32'(cfg_ack), 32'h0);
    wr(0, 7, 7);
    step();
    chk("rej_hi_err", 32'(cfg_err), 32'h1);
    chk("rej_hi_ack", 32'(cfg_ack), 32'h0);
    wr(NUM_CH, 3, 1);
    step();
    chk("rej_ch_err", 32'(cfg_err), 32'h1);
    chk("rej_ch_ack", 32'(cfg_ack), 32'h0);
    chk("rej_outs", 32'(clk_div_out), 32'h0);
    cfg_we = 1'b0;
    step();
    chk("rej_err_clear", 32'(cfg_err), 32'h0);
    ch_en = 5'b00001;
    obs_seq(0, 4, 32'b0101, 32'b0101, "rej_def0");

    // Reset mid-period on ch1 (div=5) with a pending write
    ch_en = 5'b00011;
    obs_seq(1, 2, 32'b11, 32'b01, "rst1a");
    wr(1, 9, 3);
    obs_seq(1, 1, 32'b0, 32'b0, "rst1b");
    chk("rst1_wr_ack", 32'(cfg_ack), 32'h1);
    cfg_we = 1'b0;
    rst_n  = 1'b0;
    wr(1, 9, 3);
    step();
    chk("midrst_clk", 32'(clk_div_out), 32'h0);
    chk("midrst_tick", 32'(tick), 32'h0);
    chk("midrst_ack", 32'(cfg_ack), 32'h0);
    chk("midrst_err", 32'(cfg_err), 32'h0);
    cfg_we = 1'b0;
    rst_n  = 1'b1;
    ch_en  = 5'b00010;
    obs_seq(1, 4, 32'b0101, 32'b0101, "postrst1");

    // Disable and write on the same cycle: disable wins, write applied as idle write
    ch_en = '0;
    wr(1, 3, 0);
    step();
    chk("dis_wr_ack", 32'(cfg_ack), 32'h1);
    chk("dis_wr_clk", 32'(clk_div_out[1]), 32'h0);
    chk("dis_wr_tick", 32'(tick[1]), 32'h0);
    cfg_we = 1'b0;
    ch_en  = 5'b00010;
    obs_seq(1, 4, 32'b1001, 32'b1001, "div3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
